program_monitor: RTL and testbench

- Downstream companion to the singlecycle core. It watches the core's currentpc and dmemout outputs.
- Detects when a program reaches its final PC, waits a settle window, captures the data-memory result and compares it with an expected pass code.
- A watchdog flags programs that never terminate.
- Lets benches and on-chip harnesses run back-to-back programs without hand-written PC polling loops.

---
 rtl/program_monitor.sv | 112 +++++++++++
 tb/tb_program_monitor.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/program_monitor.sv
// Watches a core's PC and data-memory output. When the program reaches its end PC
// it waits a settle window, captures dmemout and compares it with a pass code.
module program_monitor #(
  parameter int PC_W          = 64,
  parameter int DATA_W        = 64,
  parameter int WDOG_W        = 16,
  parameter int WDOG_LIMIT    = 255,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   endpc,
  input  logic [DATA_W-1:0] expected,
  input  logic [PC_W-1:0]   currentpc,
  input  logic [DATA_W-1:0] dmemout,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [DATA_W-1:0] captured,
  output logic [WDOG_W-1:0] cycles
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]   SETTLE_LD = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [WDOG_W-1:0] LIMIT_V   = WDOG_W'(WDOG_LIMIT);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_endpc;
  logic [DATA_W-1:0] r_expected;
  logic [SC_W-1:0]   r_settle;
  logic              r_pass;
  logic              r_timeout;
  logic [DATA_W-1:0] r_captured;
  logic [WDOG_W-1:0] r_cycles;

  logic [WDOG_W-1:0] w_cyc_inc;
  logic [WDOG_W-1:0] w_cyc_next;
  logic              w_at_end;
  logic              w_wdog_hit;

  // cycles is a saturating counter; the watchdog compares against the
  // post-increment value so a limit of N fires on the edge that makes cycles == N
  assign w_cyc_inc  = r_cycles + 1'b1;
  assign w_cyc_next = (&r_cycles) ? r_cycles : w_cyc_inc;
  assign w_at_end   = (currentpc >= r_endpc);
  assign w_wdog_hit = (w_cyc_inc == LIMIT_V);

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_endpc    <= '0;
      r_expected <= '0;
      r_settle   <= '0;
      r_pass     <= 1'b0;
      r_timeout  <= 1'b0;
      r_captured <= '0;
      r_cycles   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_endpc    <= endpc;
            r_expected <= expected;
            r_cycles   <= '0;
            r_pass     <= 1'b0;
            r_timeout  <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_cycles <= w_cyc_next;
          // end-PC detection wins over the watchdog on the same edge
          if (w_at_end) begin
            r_settle <= SETTLE_LD;
            r_state  <= S_SETTLE;
          end else if (w_wdog_hit) begin
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
            r_state   <= S_DONE;
          end
        end
        S_SETTLE: begin
          r_cycles <= w_cyc_next;
          if (r_settle == '0) begin
            r_captured <= dmemout;
            r_pass     <= (dmemout == r_expected);
            r_timeout  <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state == S_RUN) || (r_state == S_SETTLE);
  assign done     = (r_state == S_DONE);
  assign pass     = r_pass;
  assign timeout  = r_timeout;
  assign captured = r_captured;
  assign cycles   = r_cycles;

endmodule

// File: tb/tb_program_monitor.sv
// Bench for program_monitor: directed scenarios plus randomized programs, all
// predicted by a per-run model that scans the planned PC trace for the end edge.
module tb_program_monitor;
  localparam int LIMIT  = 255;
  localparam int SETTLE = 1;
  localparam int MAXE   = 300;

  logic        CLK = 1'b0;
  logic        reset, start;
  logic [63:0] endpc, expected, currentpc, dmemout;
  logic        busy, done, pass, timeout;
  logic [63:0] captured;
  logic [15:0] cycles;

  program_monitor #(.PC_W(64), .DATA_W(64), .WDOG_W(16), .WDOG_LIMIT(LIMIT),
                    .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .reset(reset), .start(start), .endpc(endpc), .expected(expected),
    .currentpc(currentpc), .dmemout(dmemout), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .captured(captured), .cycles(cycles));

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;
  logic [63:0] pcs [0:MAXE];
  logic [63:0] dms [0:MAXE];
  logic [63:0] m_cap;
  int          e_fin, e_cyc;
  logic        e_pass, e_to;
  logic [63:0] e_cap;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge n (n>=1) sees pcs[n]; first n with pcs[n] >= endpc ends RUN, capture
  // happens SETTLE edges later. No hit by edge LIMIT means timeout at edge LIMIT.
  task automatic predict(input logic [63:0] ep, input logic [63:0] ex);
    e_fin = 0;
    for (int n = 1; n <= LIMIT; n++) begin
      if (pcs[n] >= ep) begin
        e_fin = n + SETTLE; e_to = 1'b0; e_cap = dms[e_fin];
        e_pass = (e_cap == ex); e_cyc = e_fin;
        break;
      end
      if (n == LIMIT) begin
        e_fin = LIMIT; e_to = 1'b1; e_pass = 1'b0; e_cap = m_cap; e_cyc = LIMIT;
      end
    end
  endtask

  task automatic run(input string nm, input logic [63:0] ep, input logic [63:0] ex,
                     input int ss);
    int seen;
    seen = 0;
    predict(ep, ex);
    endpc = ep; expected = ex; start = 1'b1;
    currentpc = '1; dmemout = {$urandom, $urandom};
    @(posedge CLK); #1;
    start = 1'b0; endpc = {$urandom, $urandom}; expected = {$urandom, $urandom};
    chk({nm, ":busy_after_start"}, busy, 1);
    chk({nm, ":cycles_after_start"}, cycles, 0);
    chk({nm, ":done_after_start"}, done, 0);
    for (int n = 1; n <= MAXE; n++) begin
      currentpc = pcs[n]; dmemout = dms[n];
      start = (n == ss);
      if (n == ss) endpc = '0;
      @(posedge CLK); #1;
      start = 1'b0;
      if (done) begin seen = n; break; end
    end
    chk({nm, ":done_edge"}, 64'(seen), 64'(e_fin));
    chk({nm, ":pass"}, pass, e_pass);
    chk({nm, ":timeout"}, timeout, e_to);
    chk({nm, ":captured"}, captured, e_cap);
    chk({nm, ":cycles"}, cycles, 64'(e_cyc));
    chk({nm, ":busy_done"}, busy, 0);
    m_cap = e_cap;
    currentpc = {$urandom, $urandom}; dmemout = {$urandom, $urandom};
    @(posedge CLK); #1;
    chk({nm, ":done_hold"}, done, 1);
    chk({nm, ":cycles_hold"}, cycles, 64'(e_cyc));
  endtask

  initial begin
    int mode, ss;
    logic [63:0] ep, ex;
    reset = 1'b1; start = 1'b0; endpc = '0; expected = '0; currentpc = '0; dmemout = '0;
    m_cap = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst:busy", busy, 0);      chk("rst:done", done, 0);
    chk("rst:pass", pass, 0);      chk("rst:timeout", timeout, 0);
    chk("rst:captured", captured, 0); chk("rst:cycles", cycles, 0);
    reset = 1'b0;
    @(posedge CLK); #1;
    chk("idle:busy", busy, 0);

    // watchdog, with a start pulse on the timeout edge that must be ignored
    for (int n = 0; n <= MAXE; n++) begin pcs[n] = 64'h10; dms[n] = {$urandom, $urandom}; end
    run("wdog", 64'h34, 64'hF, LIMIT);

    // normal pass with a start pulse mid-run that must be ignored
    for (int n = 0; n <= MAXE; n++) begin pcs[n] = 64'(4 * (n - 1)); dms[n] = 64'h5; end
    dms[15] = 64'hF;
    run("pass", 64'h34, 64'hF, 5);

    dms[15] = 64'hE;
    run("mismatch", 64'h34, 64'hF, 0);

    // end PC first seen on the edge the watchdog would fire
    for (int n = 0; n <= MAXE; n++) begin
      pcs[n] = (n < LIMIT) ? 64'h0 : 64'h34; dms[n] = 64'hF;
    end
    run("simul", 64'h34, 64'hF, 0);

    // restart from DONE with new targets
    for (int n = 0; n <= MAXE; n++) begin pcs[n] = 64'(4 * (n - 1)); dms[n] = 64'h3; end
    run("restart", 64'h8, 64'h3, 0);

    // asynchronous reset in the middle of a run
    endpc = 64'h1000; expected = 64'h1; start = 1'b1; currentpc = '0;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #3 reset = 1'b1;
    #1;
    chk("arst:busy", busy, 0);      chk("arst:done", done, 0);
    chk("arst:pass", pass, 0);      chk("arst:timeout", timeout, 0);
    chk("arst:captured", captured, 0); chk("arst:cycles", cycles, 0);
    m_cap = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("arst:idle_busy", busy, 0);
    chk("arst:idle_done", done, 0);

    for (int r = 0; r < 25; r++) begin
      mode = $urandom_range(0, 2);
      ex = {$urandom, $urandom};
      case (mode)
        0: ep = 64'(4 * $urandom_range(1, 80));
        1: ep = {$urandom, $urandom};
        default: ep = {1'b1, 31'($urandom), $urandom};
      endcase
      for (int n = 0; n <= MAXE; n++) begin
        case (mode)
          0: pcs[n] = 64'(4 * (n - 1));
          1: pcs[n] = {$urandom, $urandom};
          default: pcs[n] = {1'b0, 31'($urandom), $urandom};
        endcase
        dms[n] = ($urandom_range(0, 1) == 1) ? ex : {$urandom, $urandom};
      end
      predict(ep, ex);
      ss = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e_fin) : 0;
      run($sformatf("rnd%0d", r), ep, ex, ss);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
